// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 receive path and the
//             downstream keyboard controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int          PS2_DATA_BITS = 8;
    localparam logic [7:0]  PS2_EXT       = 8'hE0;
    localparam logic [7:0]  PS2_BREAK     = 8'hF0;

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ============================================================================
//  Module   : ps2_clk_filter
//  Purpose  : 2-FF synchroniser and level glitch filter for the PS/2 clock,
//             producing a one-cycle strobe on each filtered falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic kclk_i,
    output logic fall_o
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_filt;
    logic       r_filt_prev;
    logic [7:0] r_cnt;

    // Everything resets high so releasing reset never looks like a falling edge.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_filt      <= 1'b1;
            r_filt_prev <= 1'b1;
            r_cnt       <= 8'd0;
        end else begin
            r_sync1     <= kclk_i;
            r_sync2     <= r_sync1;
            r_filt_prev <= r_filt;
            if (r_sync2 == r_filt) begin
                r_cnt <= 8'd0;
            end else if (r_cnt == 8'(FILTER_LEN - 1)) begin
                r_filt <= r_sync2;
                r_cnt  <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign fall_o = r_filt_prev & ~r_filt;

endmodule

`default_nettype wire

// File: rtl/ps2_receiver.sv
// ============================================================================
//  Module   : ps2_receiver
//  Purpose  : PS/2 device-to-host frame receiver; delivers one checked scan
//             code byte per 11-bit frame with single-cycle status strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic [7:0] scan_code_o,
    output logic       scan_code_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic                     w_fall;
    logic                     r_kdata_s1;
    logic                     r_kdata_s2;
    ps2_state_t               r_state;
    logic [2:0]               r_bit_cnt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic                     r_parity;
    logic [TO_W-1:0]          r_timeout;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .kclk_i   (kclk_i),
        .fall_o   (w_fall)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_kdata_s1 <= 1'b1;
            r_kdata_s2 <= 1'b1;
        end else begin
            r_kdata_s1 <= kdata_i;
            r_kdata_s2 <= r_kdata_s1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state           <= IDLE;
            r_bit_cnt         <= 3'd0;
            r_shift           <= '0;
            r_parity          <= 1'b0;
            r_timeout         <= '0;
            scan_code_o       <= 8'd0;
            scan_code_valid_o <= 1'b0;
            parity_err_o      <= 1'b0;
            frame_err_o       <= 1'b0;
        end else begin
            scan_code_valid_o <= 1'b0;
            parity_err_o      <= 1'b0;
            frame_err_o       <= 1'b0;

            if (r_state == IDLE) begin
                r_timeout <= '0;
                if (w_fall && !r_kdata_s2) begin
                    r_state   <= DATA;
                    r_bit_cnt <= 3'd0;
                end
            end else if (w_fall) begin
                r_timeout <= '0;
                case (r_state)
                    DATA: begin
                        r_shift   <= {r_kdata_s2, r_shift[PS2_DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= r_kdata_s2;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        // A bad stop bit masks any parity verdict.
                        if (!r_kdata_s2) begin
                            frame_err_o <= 1'b1;
                        end else if ((^r_shift ^ r_parity) == 1'b0) begin
                            parity_err_o <= 1'b1;
                        end else begin
                            scan_code_o       <= r_shift;
                            scan_code_valid_o <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_timeout == TO_W'(TIMEOUT_CYCLES - 1)) begin
                frame_err_o <= 1'b1;
                r_state     <= IDLE;
                r_timeout   <= '0;
            end else begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

    assign busy_o = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ps2_receiver.sv
// ============================================================================
//  Module   : tb_ps2_receiver
//  Purpose  : Directed self-checking bench for ps2_receiver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int FLEN = 8;
    localparam int TO   = 500;
    localparam int HALF = 20;

    logic       clk;
    logic       resetn;
    logic       kclk;
    logic       kdata;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;
    int n_multi = 0;
    int cyc     = 0;
    int ferr_cyc = 0;
    int last_fall_cyc = 0;
    logic [7:0] codes[$];

    ps2_receiver #(
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i             (clk),
        .resetn_i          (resetn),
        .kclk_i            (kclk),
        .kdata_i           (kdata),
        .scan_code_o       (scan_code),
        .scan_code_valid_o (scan_valid),
        .parity_err_o      (parity_err),
        .frame_err_o       (frame_err),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (scan_valid) begin
            n_valid = n_valid + 1;
            codes.push_back(scan_code);
        end
        if (parity_err) n_perr = n_perr + 1;
        if (frame_err) begin
            n_ferr   = n_ferr + 1;
            ferr_cyc = cyc;
        end
        if ($countones({scan_valid, parity_err, frame_err}) > 1) n_multi = n_multi + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip,
                                              input logic stop);
        return {stop, (~^d) ^ par_flip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            kdata = frame[i];
            cycles(HALF);
            kclk = 1'b0;
            last_fall_cyc = cyc;
            cycles(HALF);
            kclk = 1'b1;
        end
        kdata = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] frame);
        send_bits(frame, 11);
        cycles(30);
    endtask

    task automatic test_reset;
        checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", scan_code); end
        checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", scan_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single;
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(mk_frame(8'h1C, 1'b0, 1'b1));
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL single_valid_cnt got %0d want 1", n_valid - v0); end
        checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL single_code got %h want 1c", scan_code); end
        checks++; if ((n_perr - p0) + (n_ferr - f0) !== 0) begin errors++; $display("FAIL single_errs got %0d want 0", (n_perr - p0) + (n_ferr - f0)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        logic [7:0] want[3];
        want[0] = PS2_EXT; want[1] = PS2_BREAK; want[2] = 8'h1C;
        codes.delete();
        v0 = n_valid; e0 = n_perr + n_ferr;
        for (int i = 0; i < 3; i++) send_bits(mk_frame(want[i], 1'b0, 1'b1), 11);
        cycles(30);
        checks++; if (n_valid - v0 !== 3) begin errors++; $display("FAIL b2b_valid_cnt got %0d want 3", n_valid - v0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (codes.size() <= i) begin errors++; $display("FAIL b2b_code%0d got none want %h", i, want[i]); end
            else if (codes[i] !== want[i]) begin errors++; $display("FAIL b2b_code%0d got %h want %h", i, codes[i], want[i]); end
        end
        checks++; if (n_perr + n_ferr - e0 !== 0) begin errors++; $display("FAIL b2b_errs got %0d want 0", n_perr + n_ferr - e0); end
    endtask

    task automatic test_parity;
        int v0, p0;
        v0 = n_valid; p0 = n_perr;
        send_frame(mk_frame(8'h5C, 1'b1, 1'b1));
        checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_perr_cnt got %0d want 1", n_perr - p0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL parity_valid_cnt got %0d want 0", n_valid - v0); end
        checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL parity_code got %h want 1c", scan_code); end
    endtask

    task automatic test_stop_bit;
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(mk_frame(8'hA5, 1'b0, 1'b0));
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_ferr_cnt got %0d want 1", n_ferr - f0); end
        checks++; if ((n_perr - p0) + (n_valid - v0) !== 0) begin errors++; $display("FAIL stop_other got %0d want 0", (n_perr - p0) + (n_valid - v0)); end
        checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL stop_code got %h want 1c", scan_code); end
    endtask

    task automatic test_timeout;
        int f0, v0, t0, budget, lo, hi;
        f0 = n_ferr; v0 = n_valid;
        send_bits(mk_frame(8'h00, 1'b0, 1'b1), 6);
        t0 = last_fall_cyc;
        cycles(20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid got %b want 1", busy); end
        budget = TO + 200;
        while (n_ferr == f0 && budget > 0) begin cycles(1); budget--; end
        cycles(2);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL timeout_ferr_cnt got %0d want 1", n_ferr - f0); end
        lo = t0 + TO + FLEN - 2;
        hi = t0 + TO + FLEN + 6;
        checks++; if (ferr_cyc < lo || ferr_cyc > hi) begin errors++; $display("FAIL timeout_delay got %0d want %0d..%0d", ferr_cyc - t0, lo - t0, hi - t0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got %b want 0", busy); end
        checks++; if (n_valid - v0 !== 0 || scan_code !== 8'h1C) begin errors++; $display("FAIL timeout_code got %h want 1c", scan_code); end
        send_frame(mk_frame(8'hFF, 1'b0, 1'b1));
        checks++; if (n_valid - v0 !== 1 || scan_code !== 8'hFF) begin errors++; $display("FAIL timeout_next got %h want ff", scan_code); end
    endtask

    task automatic test_glitch_and_reset;
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        kclk = 1'b0;
        cycles(3);
        kclk = 1'b1;
        cycles(30);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
        checks++; if ((n_valid - v0) + (n_perr - p0) + (n_ferr - f0) !== 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0)); end

        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 4);
        cycles(15);
        resetn = 1'b0;
        cycles(3);
        checks++; if ({scan_code, scan_valid, parity_err, frame_err, busy} !== 12'h000) begin
            errors++; $display("FAIL midreset_outputs got %h want 000", {scan_code, scan_valid, parity_err, frame_err, busy});
        end
        resetn = 1'b1;
        cycles(5);
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        send_frame(mk_frame(8'h5A, 1'b0, 1'b1));
        checks++; if (n_valid - v0 !== 1 || scan_code !== 8'h5A) begin errors++; $display("FAIL midreset_next got %h want 5a", scan_code); end
        checks++; if ((n_ferr - f0) + (n_perr - p0) !== 0) begin errors++; $display("FAIL midreset_errs got %0d want 0", (n_ferr - f0) + (n_perr - p0)); end
    endtask

    initial begin
        resetn = 1'b0;
        kclk   = 1'b1;
        kdata  = 1'b1;
        cycles(4);
        test_reset();
        resetn = 1'b1;
        cycles(10);
        test_single();
        test_back_to_back();
        test_parity();
        test_stop_bit();
        test_timeout();
        test_glitch_and_reset();
        checks++; if (n_multi !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", n_multi); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
PS/2 device-to-host frame receiver. It sits directly upstream of the keyboard peripheral controller in riscv_unit and is driven by the raw kclk_i/kdata_i board pins. It synchronises and filters the PS/2 lines, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), checks them, and delivers one scan-code byte per frame with a single-cycle valid strobe. Multi-byte sequences (E0, F0 prefixes) pass through as separate bytes; they are not interpreted here.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised kclk samples required before the filtered clock changes level (range 2..255).
TIMEOUT_CYCLES, 20000, clk_i cycles without a filtered kclk falling edge, while mid-frame, before the frame is aborted.

Ports:
clk_i  input  1  system clock
resetn_i  input  1  reset, asynchronous assert, active-low
kclk_i  input  1  raw PS/2 clock pin, asynchronous, idle high
kdata_i  input  1  raw PS/2 data pin, asynchronous, idle high
scan_code_o  output  8  last correctly received byte; held until the next good frame
scan_code_valid_o  output  1  one-cycle strobe, scan_code_o updated this cycle
parity_err_o  output  1  one-cycle strobe, frame rejected for a parity error
frame_err_o  output  1  one-cycle strobe, frame rejected for a bad stop bit or timeout
busy_o  output  1  high while the FSM is outside IDLE

Behaviour:
- Reset (resetn_i low, async): FSM to IDLE; bit counter, timeout counter and shift register cleared.
  - All outputs reset to 0.
  - Synchroniser flops and filtered kclk reset to 1, so no false edge is seen on release.
- Synchronisation: 2-FF synchroniser on each of kclk_i and kdata_i.
- Clock filter: a counter tracks how long the synchronised kclk has differed from the filtered level. When it differs for FILTER_LEN consecutive cycles, the filtered level flips; any agreeing sample clears the counter.
- Edge detect: fall = filtered_prev & ~filtered (one cycle). The data bit is taken from the synchronised kdata in that same cycle.
- FSM, advancing only on fall unless noted:
  - IDLE: data==0 -> DATA, bit_cnt=0. data==1 -> stay in IDLE (spurious edge ignored, no error).
  - DATA: shift right, new bit enters at MSB; bit_cnt+1. On the 8th bit (bit_cnt==7) -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP, evaluated together with the stop bit, then -> IDLE:
    - stop==0: frame_err_o strobe only (takes precedence over parity).
    - stop==1 and (^shift ^ parity)==0: parity_err_o strobe.
    - otherwise: scan_code_o <= shift, scan_code_valid_o strobe.
- Output timing: every strobe is registered and appears in the cycle after the fall that carried the stop bit. Latency from raw kclk_i falling edge to strobe is 2 + FILTER_LEN + 1 cycles (±1 for input alignment).
- At most one strobe per frame; strobes are never asserted together.
- Timeout: in DATA/PARITY/STOP the timeout counter clears on each fall and increments otherwise. When it reaches TIMEOUT_CYCLES-1: frame_err_o strobe, FSM -> IDLE, partial data discarded, scan_code_o unchanged.
- busy_o = (state != IDLE), combinational from the state register.
- Reset mid-frame: the frame is lost with no strobe. The next complete frame after release is received normally.
- kdata_i changing while kclk is low is ignored; sampling happens only on fall.

Decomposition:
- ps2_pkg holds:
  - state enum: IDLE, DATA, PARITY, STOP
  - PS2_DATA_BITS = 8
  - scan-code constants PS2_EXT = 8'hE0 and PS2_BREAK = 8'hF0, shared with the keyboard controller
- Sub-module ps2_clk_filter: 2-FF sync plus FILTER_LEN glitch filter and fall output, parameterised by FILTER_LEN. The data line uses a plain 2-FF sync inside ps2_receiver.

Test Plan:
1. Frame 0x1C with parity 0 and stop 1, kclk period 100 us -> exactly one scan_code_valid_o; scan_code_o=0x1C; no error strobes; busy_o low after the stop bit.
2. Back-to-back frames E0, F0, 1C -> three valid strobes in order with scan_code_o = E0, then F0, then 1C; zero errors.
3. Frame 0x5C after a good 0x1C, with the parity bit inverted -> one parity_err_o strobe; no valid strobe; scan_code_o stays 0x1C.
4. Frame 0xA5 with stop bit 0 and correct parity -> one frame_err_o strobe only; scan_code_o unchanged.
5. kclk stopped after 5 data bits -> frame_err_o strobe TIMEOUT_CYCLES cycles after the last fall, busy_o then 0. A following good frame 0xFF yields valid with scan_code_o=0xFF.
6. 3-cycle low glitch on kclk_i while idle (FILTER_LEN=8) -> no state change and no strobes. resetn_i pulsed low mid-frame -> all outputs 0; the next frame 0x5A is received correctly.
